// File: rtl/sram_port_arbiter_if.sv
// Bus bundle for sram_port_arbiter.
// Requester and SRAM pins share one interface.
interface sram_port_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic             hold;
  logic             wr_req;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_gnt;
  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic             rd_gnt;
  logic             rd_rsp_valid;
  logic [WIDTH-1:0] rd_rsp_data;
  logic [AW-1:0]    sram_addr;
  logic             sram_ren;
  logic             sram_wen;
  logic [WIDTH-1:0] sram_d;
  logic [WIDTH-1:0] sram_q;
  logic [31:0]      n_writes;
  logic [31:0]      n_reads;

  modport slave (
    input  hold, wr_req, wr_addr, wr_data,
    input  rd_req, rd_addr, sram_q,
    output wr_gnt, rd_gnt,
    output rd_rsp_valid, rd_rsp_data,
    output sram_addr, sram_ren,
    output sram_wen, sram_d,
    output n_writes, n_reads
  );

  modport master (
    output hold, wr_req, wr_addr, wr_data,
    output rd_req, rd_addr, sram_q,
    input  wr_gnt, rd_gnt,
    input  rd_rsp_valid, rd_rsp_data,
    input  sram_addr, sram_ren,
    input  sram_wen, sram_d,
    input  n_writes, n_reads
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between a writer and a reader.
// Ports: clk, rst (sync, active-high), bus (slave modport).
module sram_port_arbiter #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int MODE     = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  sram_port_arbiter_if.slave bus
);
  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  typedef enum logic {
    WIN_WR,
    WIN_RD
  } win_e;

  win_e        r_last;
  logic [7:0]  r_wr_wait;
  logic [7:0]  r_rd_wait;
  logic        r_rsp_valid;
  logic [31:0] r_n_writes;
  logic [31:0] r_n_reads;

  logic w_wr_gnt;
  logic w_rd_gnt;
  logic w_wr_first;

  // Tie-break: alternate in mode 0; in mode 1 the
  // writer wins unless the reader has starved.
  always_comb begin
    w_wr_gnt   = 1'b0;
    w_rd_gnt   = 1'b0;
    if (MODE == 0)
      w_wr_first = (r_last == WIN_RD);
    else
      w_wr_first = (r_rd_wait < LP_MAX_WAIT);
    if (!rst && !bus.hold) begin
      unique case (1'b1)
        (bus.wr_req && bus.rd_req): begin
          w_wr_gnt = w_wr_first;
          w_rd_gnt = !w_wr_first;
        end
        (bus.wr_req && !bus.rd_req):
          w_wr_gnt = 1'b1;
        (!bus.wr_req && bus.rd_req):
          w_rd_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_n_writes  <= '0;
      r_n_reads   <= '0;
      r_last      <= WIN_RD;
      r_wr_wait   <= '0;
      r_rd_wait   <= '0;
    end else begin
      r_rsp_valid <= w_rd_gnt;
      if (w_wr_gnt)
        r_n_writes <= r_n_writes + 32'd1;
      if (w_rd_gnt)
        r_n_reads <= r_n_reads + 32'd1;
      // Arbitration state is frozen while held.
      if (!bus.hold) begin
        if (w_wr_gnt)
          r_last <= WIN_WR;
        else if (w_rd_gnt)
          r_last <= WIN_RD;
        if (!bus.wr_req || w_wr_gnt)
          r_wr_wait <= '0;
        else if (r_wr_wait != 8'hFF)
          r_wr_wait <= r_wr_wait + 8'd1;
        if (!bus.rd_req || w_rd_gnt)
          r_rd_wait <= '0;
        else if (r_rd_wait != 8'hFF)
          r_rd_wait <= r_rd_wait + 8'd1;
      end
    end
  end

  assign bus.wr_gnt       = w_wr_gnt;
  assign bus.rd_gnt       = w_rd_gnt;
  assign bus.sram_wen     = w_wr_gnt;
  assign bus.sram_ren     = w_rd_gnt;
  assign bus.sram_addr    = w_wr_gnt ? bus.wr_addr
                                     : bus.rd_addr;
  assign bus.sram_d       = bus.wr_data;
  assign bus.rd_rsp_valid = r_rsp_valid;
  assign bus.rd_rsp_data  = r_rsp_valid ? bus.sram_q
                                        : {WIDTH{1'b0}};
  assign bus.n_writes     = r_n_writes;
  assign bus.n_reads      = r_n_reads;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter.
// Two instances: round-robin (u0) and write-priority (u1).
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   cyc_n = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   run0 = 0;
  int   max_run0 = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  sram_port_arbiter_if #(.WIDTH(32), .DEPTH(32)) b0 ();
  sram_port_arbiter_if #(.WIDTH(32), .DEPTH(32)) b1 ();

  sram_port_arbiter #(
    .WIDTH(32), .DEPTH(32), .MODE(0), .MAX_WAIT(4)
  ) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );

  sram_port_arbiter #(
    .WIDTH(32), .DEPTH(32), .MODE(1), .MAX_WAIT(4)
  ) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );

  // Behavioural single-port SRAM, one-cycle read.
  always @(posedge clk) begin
    if (b0.sram_wen) mem0[b0.sram_addr] <= b0.sram_d;
    if (b0.sram_ren) b0.sram_q <= mem0[b0.sram_addr];
    if (b1.sram_wen) mem1[b1.sram_addr] <= b1.sram_d;
    if (b1.sram_ren) b1.sram_q <= mem1[b1.sram_addr];
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0d",
               nm, act, exp, cyc_n);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor for u0: responses, idle data, invariant.
  always @(negedge clk) begin
    exp_t e;
    chk("ren_wen_excl0", 32'(b0.sram_ren & b0.sram_wen), 0);
    if (b0.rd_rsp_valid) begin
      run0++;
      if (run0 > max_run0) max_run0 = run0;
      if (q0.size() == 0) begin
        chk("rsp0_unexpected", 32'(b0.rd_rsp_valid), 0);
      end else begin
        e = q0.pop_front();
        chk("rsp0_data", b0.rd_rsp_data, e.data);
        chk("rsp0_cycle", cyc_n, e.cyc);
      end
    end else begin
      run0 = 0;
      chk("rsp0_idle_data", b0.rd_rsp_data, 0);
      if (q0.size() > 0 && q0[0].cyc <= cyc_n) begin
        chk("rsp0_missing", 32'(b0.rd_rsp_valid), 1);
        void'(q0.pop_front());
      end
    end
  end

  // Monitor for u1.
  always @(negedge clk) begin
    exp_t e;
    chk("ren_wen_excl1", 32'(b1.sram_ren & b1.sram_wen), 0);
    if (b1.rd_rsp_valid) begin
      if (q1.size() == 0) begin
        chk("rsp1_unexpected", 32'(b1.rd_rsp_valid), 0);
      end else begin
        e = q1.pop_front();
        chk("rsp1_data", b1.rd_rsp_data, e.data);
        chk("rsp1_cycle", cyc_n, e.cyc);
      end
    end else if (q1.size() > 0 && q1[0].cyc <= cyc_n) begin
      chk("rsp1_missing", 32'(b1.rd_rsp_valid), 1);
      void'(q1.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    b0.hold = 0; b0.wr_req = 0; b0.rd_req = 0;
    b0.wr_addr = 0; b0.wr_data = 0; b0.rd_addr = 0;
    b1.hold = 0; b1.wr_req = 0; b1.rd_req = 0;
    b1.wr_addr = 0; b1.wr_data = 0; b1.rd_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(b0.rd_rsp_valid), 0);
    chk("rst_nw", b0.n_writes, 0);
    chk("rst_nr", b0.n_reads, 0);
    chk("rst_nw1", b1.n_writes, 0);

    // Write 0xA5 to 3, then read 3
    cyc();
    b0.wr_req = 1; b0.wr_addr = 3; b0.wr_data = 32'hA5;
    @(negedge clk);
    chk("t1_wgnt", 32'(b0.wr_gnt), 1);
    chk("t1_rgnt0", 32'(b0.rd_gnt), 0);
    chk("t1_wen", 32'(b0.sram_wen), 1);
    cyc();
    b0.wr_req = 0; b0.rd_req = 1; b0.rd_addr = 3;
    @(negedge clk);
    chk("t1_rgnt", 32'(b0.rd_gnt), 1);
    chk("t1_ren", 32'(b0.sram_ren), 1);
    q0.push_back('{32'hA5, cyc_n + 1});
    cyc();
    b0.rd_req = 0;
    @(negedge clk);
    chk("t1_nw", b0.n_writes, 1);
    chk("t1_nr", b0.n_reads, 1);

    // Fill 0..31 with addr*3, then back-to-back reads
    for (int a = 0; a < 32; a++) begin
      cyc();
      b0.wr_req = 1; b0.wr_addr = 5'(a);
      b0.wr_data = 32'(a * 3);
      @(negedge clk);
      chk("fill_wgnt", 32'(b0.wr_gnt), 1);
    end
    max_run0 = 0;
    for (int a = 0; a < 32; a++) begin
      cyc();
      b0.wr_req = 0; b0.rd_req = 1; b0.rd_addr = 5'(a);
      @(negedge clk);
      chk("fill_rgnt", 32'(b0.rd_gnt), 1);
      q0.push_back('{32'(a * 3), cyc_n + 1});
    end
    cyc();
    b0.rd_req = 0;
    cyc();
    @(negedge clk);
    chk("fill_run", 32'(max_run0), 32);
    chk("fill_nw", b0.n_writes, 33);
    chk("fill_nr", b0.n_reads, 33);

    // Round-robin with both requests held
    cyc();
    b0.wr_req = 1; b0.wr_addr = 10; b0.wr_data = 32'h100;
    b0.rd_req = 1; b0.rd_addr = 11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_wgnt", 32'(b0.wr_gnt), 32'((k % 2) == 0));
      chk("rr_rgnt", 32'(b0.rd_gnt), 32'((k % 2) == 1));
      if ((k % 2) == 1) q0.push_back('{32'd33, cyc_n + 1});
      cyc();
      if ((k % 2) == 0) b0.wr_data = 32'h100 + 32'(k + 1);
    end
    b0.wr_req = 0; b0.rd_req = 0;
    @(negedge clk);
    chk("rr_nw", b0.n_writes, 37);
    chk("rr_nr", b0.n_reads, 37);

    // Hold after a read; response still delivered
    cyc();
    b0.rd_req = 1; b0.rd_addr = 5;
    @(negedge clk);
    chk("hold_pre_rgnt", 32'(b0.rd_gnt), 1);
    q0.push_back('{32'd15, cyc_n + 1});
    cyc();
    b0.hold = 1;
    b0.wr_req = 1; b0.wr_addr = 12; b0.wr_data = 32'h77;
    b0.rd_addr = 7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_wgnt", 32'(b0.wr_gnt), 0);
      chk("hold_rgnt", 32'(b0.rd_gnt), 0);
      chk("hold_ren", 32'(b0.sram_ren), 0);
      cyc();
    end
    b0.hold = 0;
    @(negedge clk);
    chk("unhold_wgnt", 32'(b0.wr_gnt), 1);
    chk("unhold_rgnt", 32'(b0.rd_gnt), 0);
    chk("unhold_addr", 32'(b0.sram_addr), 12);
    chk("unhold_d", b0.sram_d, 32'h77);
    cyc();
    b0.wr_req = 0;
    @(negedge clk);
    chk("unhold_rgnt2", 32'(b0.rd_gnt), 1);
    chk("unhold_raddr", 32'(b0.sram_addr), 7);
    q0.push_back('{32'd21, cyc_n + 1});
    cyc();
    b0.rd_req = 0;

    // Fixed write priority with starvation bound
    b1.wr_req = 1; b1.wr_addr = 6; b1.wr_data = 32'h66;
    @(negedge clk);
    chk("m1_prewrite", 32'(b1.wr_gnt), 1);
    cyc();
    b1.wr_addr = 8; b1.wr_data = 32'h88;
    b1.rd_req = 1; b1.rd_addr = 6;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("m1_wgnt", 32'(b1.wr_gnt), 32'((k % 5) != 4));
      chk("m1_rgnt", 32'(b1.rd_gnt), 32'((k % 5) == 4));
      if ((k % 5) == 4) q1.push_back('{32'h66, cyc_n + 1});
      cyc();
    end
    b1.wr_req = 0; b1.rd_req = 0;
    @(negedge clk);
    chk("m1_nw", b1.n_writes, 9);
    chk("m1_nr", b1.n_reads, 2);

    // Reset in the same cycle as a read request
    cyc();
    rst = 1;
    b0.rd_req = 1; b0.rd_addr = 3;
    @(negedge clk);
    chk("rst_rgnt", 32'(b0.rd_gnt), 0);
    chk("rst_ren", 32'(b0.sram_ren), 0);
    cyc();
    rst = 0;
    b0.rd_req = 0;
    @(negedge clk);
    chk("rst2_valid", 32'(b0.rd_rsp_valid), 0);
    chk("rst2_nr", b0.n_reads, 0);
    chk("rst2_nw", b0.n_writes, 0);
    chk("rst2_nw1", b1.n_writes, 0);
    chk("rst2_nr1", b1.n_reads, 0);
    chk("rst2_wen", 32'(b0.sram_wen), 0);

    cyc();
    cyc();
    @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single_port_sram instance between a write requester and a read requester.
- Drives the SRAM's addr/ren/wen/d pins and never asserts ren and wen in the same cycle. The SRAM treats that as a fatal error.
- Returns read data with a response-valid strobe and arbitrates contention by round-robin or by fixed priority with a starvation bound.
- Sits between the pipeline stages that produce and consume a buffer and the SRAM macro.

Parameters:
- WIDTH, 32, data word width; must match the SRAM WIDTH.
- DEPTH, 32, SRAM words; address width AW = $clog2(DEPTH).
- MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed write-priority with starvation guard.
- MAX_WAIT, 4, MODE 1 only: consecutive stalled-request cycles after which the starved side wins. Legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- hold  in  1  when high, no grants are issued; requests stay pending.
- wr_req  in  1  write request; must hold wr_addr/wr_data stable until wr_gnt.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- wr_gnt  out  1  combinational; wr_req & wr_gnt = write accepted this cycle.
- rd_req  in  1  read request; must hold rd_addr stable until rd_gnt.
- rd_addr  in  AW  read address.
- rd_gnt  out  1  combinational; rd_req & rd_gnt = read accepted this cycle.
- rd_rsp_valid  out  1  registered; read data valid this cycle.
- rd_rsp_data  out  WIDTH  equals sram_q when rd_rsp_valid, else 0.
- sram_addr  out  AW  SRAM address.
- sram_ren  out  1  SRAM read enable.
- sram_wen  out  1  SRAM write enable.
- sram_d  out  WIDTH  SRAM write data.
- sram_q  in  WIDTH  SRAM read data.
- n_writes  out  32  accepted-write counter, wraps at 2^32.
- n_reads  out  32  accepted-read counter, wraps at 2^32.

Behaviour:
- Reset (rst high at posedge): rd_rsp_valid=0, n_reads=n_writes=0, last_winner=READ (so the first tie goes to write), both wait counters=0.
- While rst is high, wr_gnt, rd_gnt, sram_ren and sram_wen are all forced to 0.
- Reset mid-operation: a read granted in the cycle rst is sampled produces no response.
- Grant logic is combinational from req, hold, last_winner and wait counters. At most one grant per cycle.
- sram_wen = wr_gnt and sram_ren = rd_gnt. Invariant: never both.
- sram_addr = wr_gnt ? wr_addr : rd_addr. sram_d = wr_data always.
- hold=1: both grants 0, last_winner and wait counters frozen, pending response still delivered.
- Only one requester active: it is granted the same cycle (zero-latency grant).
- Both active, MODE 0: grant the side that did not win last. last_winner updates on every grant.
- Both active, MODE 1: write wins unless rd_wait >= MAX_WAIT, in which case read wins. wr_wait/MAX_WAIT are symmetric but unreachable in practice.
- Wait counters:
  - x_wait increments on each cycle with x_req & !x_gnt & !hold, saturating at 255.
  - It clears on x_gnt or when x_req=0.
- Read latency: rd_gnt at cycle t gives rd_rsp_valid=1 for exactly cycle t+1 with rd_rsp_data=sram_q.
  - No backpressure; the consumer must take the data.
  - Back-to-back reads give a continuous valid stream.
- Read-after-write to the same address:
  - Write granted at t, read granted at t+1: the read returns the new data. No forwarding is needed; the SRAM commits during t+1.
  - Read and write at the same address can never be granted in the same cycle.
- Write-after-read: read at t, write at t+1. The response at t+1 is still valid because the SRAM q is valid for cycle t+1.
- Counters increment by 1 on each accepted transfer. Width is fixed at 32 bits with modulo wrap.

Test Plan:
- Reset, then write 0xA5 to addr 3 (one cycle), then read addr 3 -> wr_gnt=1 at t0; rd_gnt=1 at t1; rd_rsp_valid=1 only at t2 with data 0xA5; n_writes=1, n_reads=1.
- MODE 0, wr_req and rd_req held high for 8 cycles with distinct addrs -> grants alternate W,R,W,R,… starting with W; never sram_ren&sram_wen; 4 writes and 4 reads.
- MODE 1, MAX_WAIT=4, both held high -> 4 writes granted, 5th cycle read granted, then pattern repeats; max read wait is 4 cycles.
- hold=1 for 3 cycles with both requests pending, after a read granted the cycle before hold rises -> that response is still delivered; no grants during hold; grants resume the cycle hold falls.
- rst asserted in the same cycle as an accepted read -> no rd_rsp_valid next cycle; counters 0; outputs idle.
- Fill addrs 0..31 with value=addr*3, then read all back-to-back -> 32 consecutive valid responses matching, rd_rsp_valid continuous for 32 cycles.
